// File: rtl/tda_pkg.sv
// Shared types for the TDA pair collector: FSM states, pair record and a
// lowest-set-bit priority selector.
package tda_pkg;

    localparam int TDA_DATA_W     = 16;
    localparam int TDA_ADDR_W     = 12;
    localparam int TDA_LANES      = 8;
    localparam int TDA_FIFO_DEPTH = 64;
    localparam int TDA_DIM_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SCAN,
        FLUSH,
        DONE
    } tda_state_e;

    typedef struct packed {
        logic [TDA_ADDR_W-1:0] birth;
        logic [TDA_ADDR_W-1:0] death;
        logic [TDA_DIM_W-1:0]  dim;
    } pair_t;

    // Index of the lowest set bit; lanes are limited to 32, so a 32-bit view covers all.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/tda_pair_stream_unit_if.sv
// Batch-in / pair-out stream bundle of the pair collector.
interface tda_pair_stream_unit_if #(
    parameter int NUM_LANES  = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 2
);
    logic                            batch_valid;
    logic                            batch_ready;
    logic [ADDR_WIDTH-1:0]           batch_base;
    logic [NUM_LANES*ADDR_WIDTH-1:0] batch_pivot;
    logic [NUM_LANES-1:0]            batch_mask;
    logic [DIM_WIDTH-1:0]            batch_dim;
    logic                            batch_last;

    logic                            pair_valid;
    logic                            pair_ready;
    logic [ADDR_WIDTH-1:0]           pair_birth;
    logic [ADDR_WIDTH-1:0]           pair_death;
    logic [DIM_WIDTH-1:0]            pair_dim;

    modport master (
        output batch_valid, batch_base, batch_pivot, batch_mask, batch_dim, batch_last,
        output pair_ready,
        input  batch_ready,
        input  pair_valid, pair_birth, pair_death, pair_dim
    );

    modport slave (
        input  batch_valid, batch_base, batch_pivot, batch_mask, batch_dim, batch_last,
        input  pair_ready,
        output batch_ready,
        output pair_valid, pair_birth, pair_death, pair_dim
    );
endinterface

// File: rtl/tda_pair_fifo.sv
// Synchronous FIFO; the head entry is presented straight from the storage
// registers and forced to zero while empty so the read port is clean after reset.
module tda_pair_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/tda_pair_stream_unit.sv
// Persistence-pair collector: filters pivot batches lane by lane and serialises
// the surviving (birth, death, dim) pairs through an output FIFO.
module tda_pair_stream_unit
    import tda_pkg::*;
#(
    parameter int DATA_WIDTH = TDA_DATA_W,
    parameter int ADDR_WIDTH = TDA_ADDR_W,
    parameter int NUM_LANES  = TDA_LANES,
    parameter int FIFO_DEPTH = TDA_FIFO_DEPTH,
    parameter int DIM_WIDTH  = TDA_DIM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] min_persistence,
    tda_pair_stream_unit_if.slave bus,
    output logic [ADDR_WIDTH:0]   pair_count,
    output logic [ADDR_WIDTH:0]   filtered_count,
    output logic                  range_err,
    output logic                  busy,
    output logic                  done
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int FW = 2 * ADDR_WIDTH + DIM_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    // Pairs carry indices only; the filtration width is kept for interface parity.
    localparam int unused_data_width = DATA_WIDTH;

    tda_state_e st, st_nxt;

    logic [ADDR_WIDTH-1:0]                hold_base;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] hold_birth;
    logic [NUM_LANES-1:0]                 hold_keep;
    logic [DIM_WIDTH-1:0]                 hold_dim;
    logic                                 hold_last;
    logic [ADDR_WIDTH-1:0]                min_q;

    logic [NUM_LANES-1:0] lane_keep, lane_bad, lane_filt;
    logic [NUM_LANES-1:0] keep_rest;
    logic [ADDR_WIDTH:0]  filt_inc;
    logic [LW-1:0]        sel;
    logic                 do_start, accept, push;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_wdata, fifo_rdata;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [ADDR_WIDTH:0] death, birth, diff;
        logic                ordered, meets;
        assign death     = {1'b0, bus.batch_base} + (ADDR_WIDTH+1)'(i);
        assign birth     = {1'b0, bus.batch_pivot[i*ADDR_WIDTH +: ADDR_WIDTH]};
        assign diff      = death - birth;
        assign ordered   = !death[ADDR_WIDTH] && (birth < death);
        assign meets     = diff >= {1'b0, min_q};
        assign lane_keep[i] = bus.batch_mask[i] && ordered && meets;
        assign lane_bad[i]  = bus.batch_mask[i] && !ordered;
        assign lane_filt[i] = bus.batch_mask[i] && ordered && !meets;
    end

    always_comb begin
        filt_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) filt_inc = filt_inc + (ADDR_WIDTH+1)'(lane_filt[i]);
    end

    // Lowest kept lane goes first; clearing the lowest set bit gives what remains.
    assign sel        = LW'(lowest_set(32'(hold_keep)));
    assign keep_rest  = hold_keep & (hold_keep - 1'b1);
    assign fifo_wdata = {hold_birth[sel], hold_base + ADDR_WIDTH'(sel), hold_dim};

    always_comb begin
        st_nxt   = st;
        do_start = 1'b0;
        accept   = 1'b0;
        push     = 1'b0;
        if (enable) begin
            case (st)
                IDLE:    if (start) begin do_start = 1'b1; st_nxt = COLLECT; end
                COLLECT: if (bus.batch_valid) begin accept = 1'b1; st_nxt = SCAN; end
                SCAN: begin
                    push = (hold_keep != '0) && !fifo_full;
                    if ((hold_keep == '0) || (push && keep_rest == '0))
                        st_nxt = hold_last ? FLUSH : COLLECT;
                end
                FLUSH:   if (fifo_empty) st_nxt = DONE;
                DONE:    st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= IDLE;
            hold_base      <= '0;
            hold_birth     <= '0;
            hold_keep      <= '0;
            hold_dim       <= '0;
            hold_last      <= 1'b0;
            min_q          <= '0;
            pair_count     <= '0;
            filtered_count <= '0;
            range_err      <= 1'b0;
        end else begin
            st <= st_nxt;
            if (do_start) begin
                min_q          <= min_persistence;
                pair_count     <= '0;
                filtered_count <= '0;
                range_err      <= 1'b0;
            end
            if (accept) begin
                hold_base      <= bus.batch_base;
                hold_birth     <= bus.batch_pivot;
                hold_keep      <= lane_keep;
                hold_dim       <= bus.batch_dim;
                hold_last      <= bus.batch_last;
                filtered_count <= filtered_count + filt_inc;
                range_err      <= range_err | (|lane_bad);
            end
            if (push) begin
                hold_keep  <= keep_rest;
                pair_count <= pair_count + CNT_ONE;
            end
        end
    end

    tda_pair_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (bus.pair_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.batch_ready = enable && (st == COLLECT);
    assign bus.pair_valid  = !fifo_empty;
    assign {bus.pair_birth, bus.pair_death, bus.pair_dim} = fifo_rdata;
    assign busy = (st != IDLE) && (st != DONE);
    assign done = enable && (st == DONE);
endmodule
